// File: rtl/voice_allocator.sv
// Voice allocator: schedules note events onto NUM_VOICES sawtooth voices.
// Each accepted event is scanned one voice per cycle. The decision is then
// applied in a single commit cycle.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned FREQ_W     = 16,
  parameter int unsigned AGE_W      = 8
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_note_on,
  input  logic [FREQ_W-1:0]            ev_freq,
  input  logic                         panic,
  output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES-1:0]        voice_retrig,
  output logic                         steal,
  output logic [3:0]                   active_cnt
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    on_q, on_d;
  logic [FREQ_W-1:0]       lfreq_q, lfreq_d;
  logic                    match_found_q, match_found_d;
  logic [IDX_W-1:0]        match_idx_q, match_idx_d;
  logic                    free_found_q, free_found_d;
  logic [IDX_W-1:0]        free_idx_q, free_idx_d;
  logic                    old_found_q, old_found_d;
  logic [IDX_W-1:0]        old_idx_q, old_idx_d;
  logic [AGE_W-1:0]        old_age_q, old_age_d;
  logic [FREQ_W-1:0]       vfreq_q [NUM_VOICES];
  logic [FREQ_W-1:0]       vfreq_d [NUM_VOICES];
  logic [AGE_W-1:0]        age_q [NUM_VOICES];
  logic [AGE_W-1:0]        age_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]   gate_q, gate_d;
  logic [NUM_VOICES-1:0]   retrig_q, retrig_d;
  logic                    steal_q, steal_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        chosen;
  logic                    load;

  // State, candidate and voice registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      on_q          <= 1'b0;
      lfreq_q       <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vfreq_q[i] <= '0;
        age_q[i]   <= '0;
      end
      gate_q        <= '0;
      retrig_q      <= '0;
      steal_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      on_q          <= on_d;
      lfreq_q       <= lfreq_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      vfreq_q       <= vfreq_d;
      age_q         <= age_d;
      gate_q        <= gate_d;
      retrig_q      <= retrig_d;
      steal_q       <= steal_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state: accept, scan one voice per cycle, commit, with panic override.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    on_d          = on_q;
    lfreq_d       = lfreq_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    vfreq_d       = vfreq_q;
    age_d         = age_q;
    gate_d        = gate_q;
    retrig_d      = '0;
    steal_d       = 1'b0;
    chosen        = '0;
    load          = 1'b0;
    cnt_d         = '0;

    case (state_q)
      StIdle: begin
        if (ev_valid) begin
          on_d          = ev_note_on;
          lfreq_d       = ev_freq;
          idx_d         = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          old_found_d   = 1'b0;
          old_age_d     = '0;
          state_d       = StScan;
        end
      end
      StScan: begin
        if (gate_q[idx_q]) begin
          if (!match_found_q && vfreq_q[idx_q] == lfreq_q) begin
            match_found_d = 1'b1;
            match_idx_d   = idx_q;
          end
          // Strict compare keeps the lowest index on age ties.
          if (!old_found_q || age_q[idx_q] > old_age_q) begin
            old_found_d = 1'b1;
            old_idx_d   = idx_q;
            old_age_d   = age_q[idx_q];
          end
        end else if (!free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        if (on_q && lfreq_q != '0) begin
          if (match_found_q) begin
            chosen = match_idx_q;
          end else if (free_found_q) begin
            chosen = free_idx_q;
            load   = 1'b1;
          end else begin
            chosen  = old_idx_q;
            load    = 1'b1;
            steal_d = 1'b1;
          end
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == chosen) begin
              age_d[i] = '0;
            end else if (gate_q[i] && age_q[i] != '1) begin
              age_d[i] = age_q[i] + 1'b1;
            end
          end
          if (load) begin
            vfreq_d[chosen] = lfreq_q;
          end
          gate_d[chosen]   = 1'b1;
          retrig_d[chosen] = 1'b1;
        end else if (!on_q && match_found_q) begin
          gate_d[match_idx_q] = 1'b0;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Panic drops any in-flight event: no commit, but freq and age stay put.
    if (panic) begin
      state_d  = StIdle;
      gate_d   = '0;
      vfreq_d  = vfreq_q;
      age_d    = age_q;
      retrig_d = '0;
      steal_d  = 1'b0;
    end

    for (int i = 0; i < NUM_VOICES; i++) begin
      cnt_d = cnt_d + 4'(gate_d[i]);
    end
  end

  // Output packing.
  always_comb begin
    voice_freq = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_freq[i*FREQ_W +: FREQ_W] = vfreq_q[i];
    end
  end

  assign ev_ready     = (state_q == StIdle);
  assign voice_gate   = gate_q;
  assign voice_retrig = retrig_q;
  assign steal        = steal_q;
  assign active_cnt   = cnt_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed literal checks plus a randomized run
// compared every cycle against an event-level model of the allocator.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int FW = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          ev_valid = 1'b0;
  logic          ev_ready;
  logic          ev_note_on = 1'b0;
  logic [FW-1:0] ev_freq = '0;
  logic          panic = 1'b0;
  logic [NV*FW-1:0] voice_freq;
  logic [NV-1:0] voice_gate;
  logic [NV-1:0] voice_retrig;
  logic          steal;
  logic [3:0]    active_cnt;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  voice_allocator #(.NUM_VOICES(NV), .FREQ_W(FW), .AGE_W(8)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_note_on   (ev_note_on),
    .ev_freq      (ev_freq),
    .panic        (panic),
    .voice_freq   (voice_freq),
    .voice_gate   (voice_gate),
    .voice_retrig (voice_retrig),
    .steal        (steal),
    .active_cnt   (active_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Event-level model ----------------
  // m_phase counts edges left until the event takes effect; 0 means idle.
  int            m_phase;
  bit            m_on;
  logic [FW-1:0] m_f;
  logic [FW-1:0] m_freq [NV];
  bit            m_gate [NV];
  int            m_age  [NV];
  logic [NV-1:0] m_retrig;
  bit            m_steal;

  task automatic model_commit();
    int mt, fr, od, ch;
    mt = -1; fr = -1; od = -1;
    for (int i = 0; i < NV; i++) begin
      if (m_gate[i] && m_freq[i] == m_f && mt < 0) mt = i;
      if (!m_gate[i] && fr < 0) fr = i;
      if (m_gate[i] && (od < 0 || m_age[i] > m_age[od])) od = i;
    end
    if (m_on && m_f != 0) begin
      if (mt >= 0) ch = mt;
      else if (fr >= 0) begin ch = fr; m_freq[ch] = m_f; end
      else begin ch = od; m_freq[ch] = m_f; m_steal = 1'b1; end
      for (int i = 0; i < NV; i++)
        if (i != ch && m_gate[i] && m_age[i] < 255) m_age[i]++;
      m_age[ch] = 0;
      m_gate[ch] = 1'b1;
      m_retrig[ch] = 1'b1;
    end else if (!m_on && mt >= 0) begin
      m_gate[mt] = 1'b0;
    end
  endtask

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_phase = 0; m_on = 0; m_f = '0; m_retrig = '0; m_steal = 0;
      for (int i = 0; i < NV; i++) begin
        m_freq[i] = '0; m_gate[i] = 0; m_age[i] = 0;
      end
    end else begin
      m_retrig = '0;
      m_steal  = 1'b0;
      if (panic) begin
        for (int i = 0; i < NV; i++) m_gate[i] = 1'b0;
        m_phase = 0;
      end else if (m_phase == 0) begin
        if (ev_valid) begin
          m_on = ev_note_on; m_f = ev_freq; m_phase = NV + 1;
        end
      end else begin
        m_phase--;
        if (m_phase == 0) model_commit();
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge sys_clk) begin
    if (cmp_en) begin
      logic [NV*FW-1:0] evf;
      logic [NV-1:0] eg;
      int cnt;
      cnt = 0;
      for (int i = 0; i < NV; i++) begin
        evf[i*FW +: FW] = m_freq[i];
        eg[i] = m_gate[i];
        cnt += int'(m_gate[i]);
      end
      check("m_voice_freq", 64'(voice_freq), 64'(evf));
      check("m_voice_gate", 64'(voice_gate), 64'(eg));
      check("m_voice_retrig", 64'(voice_retrig), 64'(m_retrig));
      check("m_steal", 64'(steal), 64'(m_steal));
      check("m_active_cnt", 64'(active_cnt), 64'(cnt));
      check("m_ev_ready", 64'(ev_ready), 64'(m_phase == 0));
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic do_reset();
    @(posedge sys_clk); #1;
    sys_rst = 1'b1; ev_valid = 1'b0; panic = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  // Drives one event, then returns #1 after the commit edge.
  task automatic send(input bit on, input logic [FW-1:0] f);
    int n;
    n = 0;
    while (!ev_ready && n < 50) begin
      @(posedge sys_clk); #1; n++;
    end
    if (n >= 50) check("ready_timeout", 64'(ev_ready), 64'(1));
    ev_valid = 1'b1; ev_note_on = on; ev_freq = f;
    @(posedge sys_clk); #1;
    ev_valid = 1'b0;
    repeat (NV + 1) @(posedge sys_clk);
    #1;
  endtask

  logic [FW-1:0] tbl [8];

  initial begin
    tbl = '{16'd0, 16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd600, 16'd700};
    sys_rst = 1'b1;
    #12 sys_rst = 1'b0;
    #1;
    check("reset_gate", 64'(voice_gate), 64'(0));
    check("reset_freq", 64'(voice_freq), 64'(0));
    check("reset_ready", 64'(ev_ready), 64'(1));
    check("reset_cnt", 64'(active_cnt), 64'(0));
    cmp_en = 1'b1;

    // Single note-on lands on voice 0 after NV+1 busy cycles.
    @(posedge sys_clk); #1;
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_freq = 16'd440;
    @(posedge sys_clk); #1;
    ev_valid = 1'b0;
    for (int k = 0; k < NV + 1; k++) begin
      check("busy_ready", 64'(ev_ready), 64'(0));
      @(posedge sys_clk); #1;
    end
    check("on440_freq", 64'(voice_freq[15:0]), 64'(440));
    check("on440_gate", 64'(voice_gate), 64'(4'b0001));
    check("on440_retrig", 64'(voice_retrig), 64'(4'b0001));
    check("on440_cnt", 64'(active_cnt), 64'(1));
    check("on440_steal", 64'(steal), 64'(0));
    check("on440_ready", 64'(ev_ready), 64'(1));
    @(posedge sys_clk); #1;
    check("on440_retrig_off", 64'(voice_retrig), 64'(0));

    // Fill all voices, fifth note steals voice 0 (oldest).
    do_reset();
    send(1, 16'd100); send(1, 16'd200); send(1, 16'd300); send(1, 16'd400);
    check("fill_gate", 64'(voice_gate), 64'(4'b1111));
    send(1, 16'd500);
    check("steal_strobe", 64'(steal), 64'(1));
    check("steal_retrig", 64'(voice_retrig), 64'(4'b0001));
    check("steal_freq", 64'(voice_freq), 64'({16'd400, 16'd300, 16'd200, 16'd500}));
    check("steal_cnt", 64'(active_cnt), 64'(4));

    // Duplicate note-on reuses one voice; note-off releases it.
    do_reset();
    send(1, 16'd200);
    check("dup1_retrig", 64'(voice_retrig), 64'(4'b0001));
    send(1, 16'd200);
    check("dup2_retrig", 64'(voice_retrig), 64'(4'b0001));
    check("dup2_gate", 64'(voice_gate), 64'(4'b0001));
    send(0, 16'd200);
    check("off_gate", 64'(voice_gate), 64'(0));
    check("off_freq", 64'(voice_freq[15:0]), 64'(200));
    check("off_cnt", 64'(active_cnt), 64'(0));

    // Unmatched note-off and zero-freq note-on change nothing.
    send(0, 16'd999);
    check("nomatch_gate", 64'(voice_gate), 64'(0));
    check("nomatch_retrig", 64'(voice_retrig), 64'(0));
    send(1, 16'd0);
    check("zero_retrig", 64'(voice_retrig), 64'(0));
    check("zero_freq", 64'(voice_freq[15:0]), 64'(200));
    check("zero_ready", 64'(ev_ready), 64'(1));

    // Panic during scan drops the event.
    do_reset();
    send(1, 16'd100); send(1, 16'd200); send(1, 16'd300); send(1, 16'd400);
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_freq = 16'd600;
    @(posedge sys_clk); #1;
    ev_valid = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 panic = 1'b1;
    @(posedge sys_clk); #1;
    panic = 1'b0;
    check("panic_gate", 64'(voice_gate), 64'(0));
    check("panic_ready", 64'(ev_ready), 64'(1));
    check("panic_cnt", 64'(active_cnt), 64'(0));
    repeat (NV + 2) @(posedge sys_clk);
    #1;
    check("panic_dropped", 64'(voice_gate), 64'(0));
    check("panic_freq_kept", 64'(voice_freq), 64'({16'd400, 16'd300, 16'd200, 16'd100}));

    // Async reset asserted between edges while in commit.
    do_reset();
    send(1, 16'd100);
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_freq = 16'd300;
    @(posedge sys_clk); #1;
    ev_valid = 1'b0;
    repeat (NV) @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    check("arst_freq", 64'(voice_freq), 64'(0));
    check("arst_gate", 64'(voice_gate), 64'(0));
    check("arst_cnt", 64'(active_cnt), 64'(0));
    check("arst_retrig", 64'(voice_retrig), 64'(0));
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    check("arst_ready", 64'(ev_ready), 64'(1));

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      ev_valid   = ($urandom_range(0, 2) == 0);
      ev_note_on = ($urandom_range(0, 2) != 0);
      ev_freq    = tbl[$urandom_range(0, 7)];
      panic      = ($urandom_range(0, 80) == 0);
      @(posedge sys_clk); #1;
    end
    ev_valid = 1'b0; panic = 1'b0;
    repeat (NV + 3) @(posedge sys_clk);
    #1;
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
